// File: rtl/mioc_top.sv
// ADAM memory/IO controller: Z80 IO-mapped memory-map and control registers,
// memory chip-select decode, DRAM RAS/MUX/CAS sequencing, 6801 DMA handshake and resets.
module mioc_top (
   input  logic B_PHI,
   input  logic PBRST_N,
   input  logic N_CVRST,
   input  logic BA15,
   input  logic BA14,
   input  logic BA13,
   input  logic BA7,
   input  logic BA6,
   input  logic BD0,
   input  logic BD1,
   input  logic BD2,
   input  logic BD3,
   input  logic N_BWR,
   input  logic IORQ_N,
   input  logic BMREQ_N,
   input  logic BRD_N,
   input  logic BRFSH_N,
   input  logic BM1_N,
   input  logic WAIT_N,
   input  logic BUSAK_N,
   input  logic DMA_N,
   input  logic OS3_N,
   output logic RA7,
   output logic BUSRQ_N,
   output logic SPINDIS_N,
   output logic NETRST_N,
   output logic AUXDECODE1_N,
   output logic RST_N,
   output logic CPRST_N,
   output logic AUXROMCS_N,
   output logic ADDRBUFEN_N,
   output logic BOOTROMCS_N,
   output logic EN245_N,
   output logic IS3_N,
   output logic MUX,
   output logic RAS_N,
   output logic CAS1_N,
   output logic CAS2_N
);

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_REQ   = 2'd1,
      DMA_GRANT = 2'd2
   } dma_state_t;

   logic [3:0] memmap_reg;
   logic [1:0] ctrl_reg;
   logic       rst_reg;
   logic       cprst_reg;
   logic       mux_reg;
   logic       mux_next;
   logic       os3_seen_reg;
   logic       os3_seen_next;
   dma_state_t dma_state_reg;
   dma_state_t dma_state_next;

   logic [3:0] bd;
   logic       io_wr;
   logic       bus_owned;
   logic       mem_active;
   logic       refresh;
   logic [1:0] ram_sel;
   logic [1:0] cas_n;
   logic       boot_sel;
   logic       aux_sel;
   logic       auxrom_sel;
   logic       os7_sel;
   logic       unused_bm1;

   assign unused_bm1 = BM1_N;
   assign bd         = {BD3, BD2, BD1, BD0};
   // Only ports with BA7=0 belong to this chip; BA6 picks memmap vs control.
   assign io_wr      = ~IORQ_N & ~N_BWR & ~BA7;

   always_ff @(posedge B_PHI) begin
      rst_reg   <= PBRST_N & N_CVRST;
      cprst_reg <= N_CVRST;
      if (!PBRST_N) begin
         memmap_reg    <= 4'b0000;
         ctrl_reg      <= 2'b11;
         mux_reg       <= 1'b0;
         os3_seen_reg  <= 1'b0;
         dma_state_reg <= DMA_IDLE;
      end else begin
         if (io_wr && BA6) begin
            memmap_reg <= bd;
         end
         if (io_wr && !BA6) begin
            ctrl_reg <= bd[1:0];
         end
         mux_reg       <= mux_next;
         os3_seen_reg  <= os3_seen_next;
         dma_state_reg <= dma_state_next;
      end
   end

   // While the 6801 owns the bus the Z80 address is not valid, so decode is gated off.
   assign bus_owned  = (dma_state_reg == DMA_GRANT);
   assign mem_active = ~BMREQ_N & BRFSH_N & ~bus_owned;
   assign refresh    = ~BMREQ_N & ~BRFSH_N;

   always_comb begin
      ram_sel    = 2'b00;
      boot_sel   = 1'b0;
      aux_sel    = 1'b0;
      auxrom_sel = 1'b0;
      os7_sel    = 1'b0;
      if (mem_active) begin
         if (!BA15) begin
            case (memmap_reg[1:0])
               2'b00: boot_sel = ~BRD_N;
               2'b01: ram_sel[0] = 1'b1;
               2'b10: aux_sel = 1'b1;
               2'b11: begin
                  if (!BA14 && !BA13) begin
                     os7_sel = 1'b1;
                  end else begin
                     ram_sel[0] = 1'b1;
                  end
               end
               default: ram_sel = 2'b00;
            endcase
         end else begin
            case (memmap_reg[3:2])
               2'b00: ram_sel[1] = 1'b1;
               2'b01: aux_sel = 1'b1;
               2'b10: auxrom_sel = ~BRD_N;
               2'b11: os7_sel = 1'b1;
               default: ram_sel = 2'b00;
            endcase
         end
      end
   end

   // MUX flips to column address one edge into a RAM access; WAIT stretches the phase.
   always_comb begin
      mux_next = mux_reg;
      if (WAIT_N) begin
         mux_next = |ram_sel;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cas
         assign cas_n[gi] = ~(ram_sel[gi] & mux_reg);
      end
   endgenerate

   always_comb begin
      dma_state_next = dma_state_reg;
      case (dma_state_reg)
         DMA_IDLE:  if (!DMA_N)   dma_state_next = DMA_REQ;
         DMA_REQ:   if (!BUSAK_N) dma_state_next = DMA_GRANT;
         DMA_GRANT: if (DMA_N)    dma_state_next = DMA_IDLE;
         default:   dma_state_next = DMA_IDLE;
      endcase
   end

   assign os3_seen_next = (dma_state_reg == DMA_GRANT) & (os3_seen_reg | ~OS3_N);

   assign RST_N        = rst_reg;
   assign CPRST_N      = cprst_reg;
   assign NETRST_N     = ctrl_reg[0] & rst_reg;
   assign SPINDIS_N    = ctrl_reg[1];
   assign BUSRQ_N      = (dma_state_reg == DMA_IDLE);
   assign ADDRBUFEN_N  = bus_owned;
   assign IS3_N        = ~(bus_owned & ~os3_seen_reg);
   assign MUX          = mux_reg;
   assign RA7          = mux_reg ? BA14 : BA7;
   assign RAS_N        = ~((|ram_sel) | refresh);
   assign CAS1_N       = cas_n[0];
   assign CAS2_N       = cas_n[1];
   assign BOOTROMCS_N  = ~boot_sel;
   assign AUXDECODE1_N = ~aux_sel;
   assign AUXROMCS_N   = ~auxrom_sel;
   assign EN245_N      = ~os7_sel;

endmodule

// File: tb/tb_mioc_top.sv
// Bench for mioc_top: directed walk through the controller's main scenarios followed
// by random bus traffic, all checked against a behavioural model of the ADAM memory map.
module tb_mioc_top;

   logic B_PHI = 1'b0;
   logic PBRST_N, N_CVRST, BA15, BA14, BA13, BA7, BA6;
   logic BD0, BD1, BD2, BD3, N_BWR, IORQ_N, BMREQ_N, BRD_N, BRFSH_N;
   logic BM1_N, WAIT_N, BUSAK_N, DMA_N, OS3_N;
   logic RA7, BUSRQ_N, SPINDIS_N, NETRST_N, AUXDECODE1_N, RST_N, CPRST_N;
   logic AUXROMCS_N, ADDRBUFEN_N, BOOTROMCS_N, EN245_N, IS3_N, MUX, RAS_N;
   logic CAS1_N, CAS2_N;

   mioc_top dut (
      .B_PHI(B_PHI), .PBRST_N(PBRST_N), .N_CVRST(N_CVRST),
      .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
      .BD0(BD0), .BD1(BD1), .BD2(BD2), .BD3(BD3),
      .N_BWR(N_BWR), .IORQ_N(IORQ_N), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N),
      .BRFSH_N(BRFSH_N), .BM1_N(BM1_N), .WAIT_N(WAIT_N), .BUSAK_N(BUSAK_N),
      .DMA_N(DMA_N), .OS3_N(OS3_N),
      .RA7(RA7), .BUSRQ_N(BUSRQ_N), .SPINDIS_N(SPINDIS_N), .NETRST_N(NETRST_N),
      .AUXDECODE1_N(AUXDECODE1_N), .RST_N(RST_N), .CPRST_N(CPRST_N),
      .AUXROMCS_N(AUXROMCS_N), .ADDRBUFEN_N(ADDRBUFEN_N), .BOOTROMCS_N(BOOTROMCS_N),
      .EN245_N(EN245_N), .IS3_N(IS3_N), .MUX(MUX), .RAS_N(RAS_N),
      .CAS1_N(CAS1_N), .CAS2_N(CAS2_N)
   );

   always #50 B_PHI = ~B_PHI;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state, kept in terms of what the board sees.
   logic [3:0] m_memmap;
   logic [1:0] m_ctrl;
   logic       m_rst, m_cprst, m_mux, m_acked;
   int         m_phase;   // 0 idle, 1 requesting, 2 6801 owns the bus

   localparam int T_NONE = 0, T_BOOT = 1, T_RAM_LO = 2, T_RAM_HI = 3;
   localparam int T_AUX = 4, T_AUXROM = 5, T_OS7 = 6;

   task automatic check_val(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   function automatic int target();
      if (BMREQ_N || !BRFSH_N || m_phase == 2) return T_NONE;
      if (!BA15) begin
         case (m_memmap[1:0])
            2'd0: return BRD_N ? T_NONE : T_BOOT;
            2'd1: return T_RAM_LO;
            2'd2: return T_AUX;
            default: return (BA14 || BA13) ? T_RAM_LO : T_OS7;
         endcase
      end
      case (m_memmap[3:2])
         2'd0: return T_RAM_HI;
         2'd1: return T_AUX;
         2'd2: return BRD_N ? T_NONE : T_AUXROM;
         default: return T_OS7;
      endcase
   endfunction

   task automatic check_outputs();
      int  t;
      logic refresh;
      t = target();
      refresh = !BMREQ_N && !BRFSH_N;
      check_val("RST_N", RST_N, m_rst);
      check_val("CPRST_N", CPRST_N, m_cprst);
      check_val("NETRST_N", NETRST_N, m_ctrl[0] & m_rst);
      check_val("SPINDIS_N", SPINDIS_N, m_ctrl[1]);
      check_val("BUSRQ_N", BUSRQ_N, m_phase == 0);
      check_val("ADDRBUFEN_N", ADDRBUFEN_N, m_phase == 2);
      check_val("IS3_N", IS3_N, !(m_phase == 2 && !m_acked));
      check_val("MUX", MUX, m_mux);
      check_val("RA7", RA7, m_mux ? BA14 : BA7);
      check_val("BOOTROMCS_N", BOOTROMCS_N, t != T_BOOT);
      check_val("AUXDECODE1_N", AUXDECODE1_N, t != T_AUX);
      check_val("AUXROMCS_N", AUXROMCS_N, t != T_AUXROM);
      check_val("EN245_N", EN245_N, t != T_OS7);
      check_val("RAS_N", RAS_N, !(t == T_RAM_LO || t == T_RAM_HI || refresh));
      check_val("CAS1_N", CAS1_N, !(t == T_RAM_LO && m_mux));
      check_val("CAS2_N", CAS2_N, !(t == T_RAM_HI && m_mux));
   endtask

   task automatic model_edge();
      int   t;
      logic ram, acked_new;
      t = target();
      ram = (t == T_RAM_LO) || (t == T_RAM_HI);
      m_rst = PBRST_N & N_CVRST;
      m_cprst = N_CVRST;
      if (!PBRST_N) begin
         m_memmap = 4'b0000;
         m_ctrl = 2'b11;
         m_mux = 1'b0;
         m_phase = 0;
         m_acked = 1'b0;
      end else begin
         if (!IORQ_N && !N_BWR && !BA7) begin
            if (BA6) m_memmap = {BD3, BD2, BD1, BD0};
            else     m_ctrl = {BD1, BD0};
         end
         if (WAIT_N) m_mux = ram;
         acked_new = (m_phase == 2) && (m_acked || !OS3_N);
         case (m_phase)
            0: if (!DMA_N) m_phase = 1;
            1: if (!BUSAK_N) m_phase = 2;
            default: if (DMA_N) m_phase = 0;
         endcase
         m_acked = acked_new;
      end
   endtask

   // Inputs change just after a rising edge; outputs are checked mid-cycle.
   task automatic tick();
      #10;
      check_outputs();
      @(posedge B_PHI);
      model_edge();
      #1;
   endtask

   task automatic idle_bus();
      IORQ_N = 1'b1; N_BWR = 1'b1; BMREQ_N = 1'b1; BRD_N = 1'b1;
      BRFSH_N = 1'b1; WAIT_N = 1'b1;
   endtask

   task automatic set_addr(input logic [15:0] a);
      BA15 = a[15]; BA14 = a[14]; BA13 = a[13]; BA7 = a[7]; BA6 = a[6];
   endtask

   task automatic io_write(input logic [7:0] port, input logic [3:0] d);
      set_addr({8'h00, port});
      {BD3, BD2, BD1, BD0} = d;
      IORQ_N = 1'b0; N_BWR = 1'b0;
      tick();
      idle_bus();
   endtask

   task automatic mem_read(input logic [15:0] a, input int n);
      set_addr(a);
      BMREQ_N = 1'b0; BRD_N = 1'b0;
      repeat (n) tick();
      idle_bus();
      tick();
   endtask

   initial begin
      PBRST_N = 1'b0; N_CVRST = 1'b1; BM1_N = 1'b1;
      BUSAK_N = 1'b1; DMA_N = 1'b1; OS3_N = 1'b1;
      {BD3, BD2, BD1, BD0} = 4'h0;
      set_addr(16'h0000);
      idle_bus();
      @(posedge B_PHI);
      model_edge();
      #1;

      // 1000 ns of reset, then release.
      repeat (10) tick();
      PBRST_N = 1'b1;
      repeat (2) tick();

      // Control register sweep, with a boot-ROM read between writes.
      for (int d = 0; d < 16; d++) begin
         io_write(8'h00, d[3:0]);
         mem_read(16'h0000, 1);
      end

      // Internal RAM in the lower 32K.
      io_write(8'h40, 4'b0001);
      mem_read(16'h1000, 3);
      mem_read(16'h10C0, 3);

      // OS7 low, expansion ROM high, RAM above OS7.
      io_write(8'h40, 4'b1011);
      mem_read(16'h0000, 2);
      mem_read(16'h8000, 2);
      mem_read(16'h4000, 3);

      // Refresh.
      BMREQ_N = 1'b0; BRFSH_N = 1'b0;
      repeat (2) tick();
      idle_bus();
      tick();

      // Writes to BA7=1 ports are ignored.
      io_write(8'hC0, 4'b0110);
      io_write(8'h80, 4'b0000);
      tick();

      // DMA handshake.
      DMA_N = 1'b0;
      repeat (2) tick();
      BUSAK_N = 1'b0;
      repeat (2) tick();
      OS3_N = 1'b0;
      tick();
      OS3_N = 1'b1;
      tick();
      DMA_N = 1'b1;
      repeat (2) tick();
      BUSAK_N = 1'b1;
      tick();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         PBRST_N = ($urandom_range(0, 63) != 0);
         N_CVRST = ($urandom_range(0, 31) != 0);
         if ($urandom_range(0, 2) == 0)
            set_addr(16'($urandom_range(0, 65535)));
         {BD3, BD2, BD1, BD0} = 4'($urandom_range(0, 15));
         IORQ_N  = ($urandom_range(0, 3) != 0);
         N_BWR   = 1'($urandom_range(0, 1));
         BMREQ_N = ($urandom_range(0, 3) == 0);
         BRD_N   = 1'($urandom_range(0, 1));
         BRFSH_N = ($urandom_range(0, 5) != 0);
         WAIT_N  = ($urandom_range(0, 3) != 0);
         BUSAK_N = 1'($urandom_range(0, 1));
         DMA_N   = ($urandom_range(0, 4) != 0);
         OS3_N   = ($urandom_range(0, 2) != 0);
         BM1_N   = 1'($urandom_range(0, 1));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mioc_top.md
Name: mioc_top

Overview:
- Memory/IO controller (MIOC) for the ADAM computer board; sits between the buffered Z80 bus, the master 6801 and the DRAM array.
- Holds the memory-map and network/control registers written by Z80 IO cycles.
- Decodes memory chip selects, sequences DRAM RAS/MUX/CAS, runs the 6801 DMA bus handshake and generates system resets.

Parameters:
- none

Ports:
- B_PHI in 1 Z80 clock; the only clock, all registers update on its rising edge
- PBRST_N in 1 ADAM reset switch; synchronous active-low reset
- N_CVRST in 1 game reset, active-low, sampled synchronously
- BA15,BA14,BA13,BA7,BA6 in 1 each buffered address lines
- BD0..BD3 in 1 each buffered data bits 0-3
- N_BWR in 1 buffered write, active-low
- IORQ_N in 1 Z80 IO request, active-low
- BMREQ_N in 1 memory request, active-low
- BRD_N in 1 memory read, active-low
- BRFSH_N in 1 refresh, active-low
- BM1_N in 1 M1 cycle; reserved, no function
- WAIT_N in 1 wait state, active-low
- BUSAK_N in 1 Z80 bus acknowledge, active-low
- DMA_N in 1 6801 DMA request, active-low
- OS3_N in 1 6801 strobe, active-low
- RA7 out 1 multiplexed DRAM address MSB
- BUSRQ_N out 1 Z80 bus request, active-low
- SPINDIS_N out 1 spinner interrupt disable, active-low
- NETRST_N out 1 AdamNet reset, active-low
- AUXDECODE1_N out 1 expansion-RAM decode, active-low
- RST_N out 1 system reset, active-low
- CPRST_N out 1 game reset, active-low
- AUXROMCS_N out 1 expansion ROM select, active-low
- ADDRBUFEN_N out 1 Z80 address buffer enable, active-low
- BOOTROMCS_N out 1 SmartWriter/EOS ROM select, active-low
- EN245_N out 1 ColecoVision onboard decode enable, active-low
- IS3_N out 1 strobe to 6801, active-low
- MUX out 1 DRAM row/column select (0=row)
- RAS_N out 1 DRAM row strobe, active-low
- CAS1_N out 1 DRAM column strobe, lower 32K
- CAS2_N out 1 DRAM column strobe, upper 32K

Behaviour:
- Reset
  - PBRST_N low at a B_PHI rising edge: MEMMAP=4'b0000, CTRL=2'b11, MUX=0, DMA state=IDLE.
  - RST_N and NETRST_N are registered copies of (PBRST_N & N_CVRST).
  - CPRST_N is a registered copy of N_CVRST.
- IO write strobe: IORQ_N=0 & N_BWR=0, sampled at the rising edge.
  - BA7=0, BA6=1: MEMMAP <= BD3..BD0.
  - BA7=0, BA6=0: CTRL <= BD1..BD0.
  - BA7=1: ignored.
- CTRL outputs (NETRST_N/SPINDIS_N are registered and change at the edge after the write):
  - NETRST_N = CTRL[0] & the registered reset term.
  - SPINDIS_N = CTRL[1].
- Memory decode (combinational; active only when BMREQ_N=0 & BRFSH_N=1 & ADDRBUFEN_N=0).
  - Lower 32K (BA15=0), selected by MEMMAP[1:0]:
    - 00: BOOTROMCS_N=0 when BRD_N=0.
    - 01: internal RAM, via CAS1_N.
    - 10: AUXDECODE1_N=0.
    - 11: BA14:13=00 gives EN245_N=0 (OS7); otherwise internal RAM.
  - Upper 32K (BA15=1), selected by MEMMAP[3:2]:
    - 00: internal RAM, via CAS2_N.
    - 01: AUXDECODE1_N=0.
    - 10: AUXROMCS_N=0 when BRD_N=0.
    - 11: EN245_N=0.
  - All selects are high otherwise.
- DRAM sequencing
  - RAS_N = 0 combinationally when an internal-RAM access is decoded, or when BMREQ_N=0 & BRFSH_N=0 (refresh).
  - MUX: set at the first rising edge with a non-refresh RAS active; cleared when RAS drops.
  - MUX holds its value while WAIT_N=0.
  - CAS1_N/CAS2_N = 0 when RAS is active & MUX=1 & region matches. Refresh never asserts CAS.
  - RA7 = MUX ? BA14 : BA7.
- DMA handshake. State sequence: IDLE -> REQ -> GRANT -> IDLE.
  - IDLE: DMA_N=0 -> REQ; BUSRQ_N=0.
  - REQ: BUSAK_N=0 -> GRANT; ADDRBUFEN_N=1, IS3_N=0.
  - GRANT: IS3_N returns high once OS3_N=0 is seen.
  - GRANT: DMA_N=1 -> IDLE; BUSRQ_N=1, ADDRBUFEN_N=0.
  - Reset mid-DMA returns to IDLE immediately.
- Simultaneous IO write and reset: reset wins.

Test Plan:
- Hold PBRST_N=0 for 1000ns, then release:
  - During reset: RST_N=0, NETRST_N=0, BUSRQ_N=1, ADDRBUFEN_N=0.
  - After the first edge following release: RST_N=1.
- IO writes with BA7=0, BA6=0, data 0..15, three clocks each:
  - NETRST_N follows bit0 and SPINDIS_N follows bit1 after each write.
  - MEMMAP stays 0; BOOTROMCS_N=0 on a read at 0x0000.
- Write MEMMAP=4'b0001 (BA6=1), then read 0x1000:
  - RAS_N=0, MUX=1 one edge later, then CAS1_N=0.
  - BOOTROMCS_N=1, RA7 switches from BA7 to BA14.
- MEMMAP=4'b1011:
  - Read at 0x0000: EN245_N=0.
  - Read at 0x8000: AUXROMCS_N=0.
  - Read at 0x4000: CAS1_N path.
- Refresh cycle (BMREQ_N=0, BRFSH_N=0) -> RAS_N=0, CAS1_N=CAS2_N=1, MUX=0.
- DMA_N=0 -> BUSRQ_N=0; then BUSAK_N=0 -> ADDRBUFEN_N=1, IS3_N=0; then DMA_N=1 -> BUSRQ_N=1, ADDRBUFEN_N=0.
